// File: rtl/scroll_shift_serializer.sv
// rtl/scroll_shift_serializer.sv - parallel-load serializer with rate divider, direction and rotate modes
module scroll_shift_serializer #(
    parameter int WIDTH = 12,
    parameter int DIV   = 50_000_000,
    parameter int CNT_W = 26,
    localparam int BL_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             dir,
    input  logic             rotate,
    output logic             load_ready,
    output logic             serial_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_q,
    output logic [BL_W-1:0]  bits_left
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic [BL_W-1:0]   r_bits;
    logic              r_dir;
    logic              r_rot;
    logic              r_done;

    logic              w_accept;
    logic              w_tick;
    logic              w_final;
    logic              w_fill;
    logic [WIDTH-1:0]  w_shifted;

    // Handshake and tick qualifiers; enable gates only the RUN datapath
    assign w_accept = (r_state == S_IDLE) && load_valid;
    assign w_tick   = (r_state == S_RUN) && enable && (r_cnt == '0);
    assign w_final  = w_tick && (r_bits == BL_W'(1));

    // Next register contents on a tick: the leaving bit recirculates in rotate mode
    always_comb begin
        w_fill    = 1'b0;
        w_shifted = r_data;
        if (r_dir) begin
            w_fill    = r_rot ? r_data[0] : 1'b0;
            w_shifted = {w_fill, r_data[WIDTH-1:1]};
        end else begin
            w_fill    = r_rot ? r_data[WIDTH-1] : 1'b0;
            w_shifted = {r_data[WIDTH-2:0], w_fill};
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: leave IDLE on acceptance, return after the final tick
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_RUN;
            S_RUN:   if (w_final)  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: load on acceptance, count down and shift while enabled in RUN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_bits <= '0;
            r_dir  <= 1'b0;
            r_rot  <= 1'b0;
        end else if (w_accept) begin
            r_data <= load_data;
            r_cnt  <= CNT_RELOAD;
            r_bits <= BL_W'(WIDTH);
            r_dir  <= dir;
            r_rot  <= rotate;
        end else if ((r_state == S_RUN) && enable) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end else begin
                r_cnt  <= CNT_RELOAD;
                r_bits <= r_bits - BL_W'(1);
                r_data <= w_shifted;
            end
        end
    end

    // One-cycle completion pulse aligned with the return to IDLE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_final;
        end
    end

    assign load_ready = (r_state == S_IDLE);
    assign busy       = (r_state == S_RUN);
    assign done       = r_done;
    assign data_q     = r_data;
    assign bits_left  = r_bits;
    assign serial_out = r_dir ? r_data[0] : r_data[WIDTH-1];

endmodule
